// File: rtl/frame_word_assembler.sv
// Packs narrow input words LSB-first into one wide frame, with one fill and one output register.
// Optional idle auto-flush is compiled in with `define FRAME_TIMEOUT_EN.
module frame_word_assembler #(
  parameter int DATA_WIDTH = 16000,
  parameter int IN_WIDTH   = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  m_axis_c2h_aclk,
  input  logic                  m_axis_c2h_aresetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_flush,
  output logic                  data_valid,
  input  logic                  data_next,
  output logic [DATA_WIDTH-1:0] data,
  output logic [15:0]           frame_cnt
);

  localparam int WORDS  = (DATA_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam int FILL_W = WORDS * IN_WIDTH;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("frame_word_assembler: TIMEOUT must be in 1..65535");
  end

  typedef enum logic {ST_FILL, ST_WAIT} state_t;

  state_t                state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d, wcnt_next;
  logic [FILL_W-1:0]     fill_q, fill_d, fill_next;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  data_valid_q, data_valid_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  logic accept, close, slot_free, load, timeout_hit;

  assign in_ready   = m_axis_c2h_aresetn & (state_q == ST_FILL);
  assign data_valid = data_valid_q;
  assign data       = data_q;
  assign frame_cnt  = frame_cnt_q;

  assign accept    = in_valid & in_ready;
  assign wcnt_next = wcnt_q + WCNT_W'(accept);
  assign slot_free = ~data_valid_q | data_next;
  // A close needs at least one word in the frame, so a bare flush never makes an empty frame.
  assign close     = (state_q == ST_FILL) &
                     ((wcnt_next == WCNT_W'(WORDS)) |
                      ((in_flush | timeout_hit) & (wcnt_next != '0)));
  assign load      = slot_free & (close | (state_q == ST_WAIT));

  always_comb begin
    fill_next = fill_q;
    if (accept) begin
      fill_next[int'(wcnt_q) * IN_WIDTH +: IN_WIDTH] = in_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_next;
    fill_d       = fill_next;
    data_d       = data_q;
    data_valid_d = data_valid_q & ~data_next;
    frame_cnt_d  = frame_cnt_q;
    if (load) begin
      data_d       = fill_next[DATA_WIDTH-1:0];
      data_valid_d = 1'b1;
      fill_d       = '0;
      wcnt_d       = '0;
      frame_cnt_d  = frame_cnt_q + 16'd1;
      state_d      = ST_FILL;
    end else if (close) begin
      state_d = ST_WAIT;
    end
  end

  always_ff @(posedge m_axis_c2h_aclk) begin
    if (!m_axis_c2h_aresetn) begin
      state_q      <= ST_FILL;
      wcnt_q       <= '0;
      fill_q       <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      fill_q       <= fill_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;

  assign timeout_hit = (state_q == ST_FILL) & (wcnt_q != '0) & (idle_q == 16'(TIMEOUT));

  always_comb begin
    idle_d = '0;
    if (state_q == ST_FILL && !accept && !close && wcnt_q != '0) begin
      idle_d = idle_q + 16'd1;
    end
  end

  always_ff @(posedge m_axis_c2h_aclk) begin
    if (!m_axis_c2h_aresetn) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_frame_word_assembler.sv
// Directed bench for frame_word_assembler with a 256-bit frame of four 64-bit words.
module tb_frame_word_assembler;

  localparam int DW = 256;
  localparam int IW = 64;

  logic          clk;
  logic          aresetn;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_flush;
  logic          data_valid;
  logic          data_next;
  logic [DW-1:0] data;
  logic [15:0]   frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  frame_word_assembler #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .TIMEOUT(8)) dut (
    .m_axis_c2h_aclk   (clk),
    .m_axis_c2h_aresetn(aresetn),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_flush          (in_flush),
    .data_valid        (data_valid),
    .data_next         (data_next),
    .data              (data),
    .frame_cnt         (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
  endtask

  logic [IW-1:0] w [0:7];
  logic          stuck;

  initial begin
    for (int i = 0; i < 8; i++) w[i] = {16{4'(i + 1)}};
    aresetn = 1'b0; in_valid = 1'b0; in_data = '0; in_flush = 1'b0; data_next = 1'b0;
    tick(); tick();

    // reset state
    check("rst_in_ready", DW'(in_ready), DW'(0));
    check("rst_valid", DW'(data_valid), DW'(0));
    check("rst_data", data, '0);
    check("rst_cnt", DW'(frame_cnt), DW'(0));
    aresetn = 1'b1;
    tick();
    check("post_rst_in_ready", DW'(in_ready), DW'(1));

    // full frame
    data_next = 1'b1;
    send(w[0]); send(w[1]); send(w[2]);
    check("full_not_yet", DW'(data_valid), DW'(0));
    send(w[3]);
    in_valid = 1'b0;
    check("full_valid", DW'(data_valid), DW'(1));
    check("full_data", data, {w[3], w[2], w[1], w[0]});
    check("full_cnt", DW'(frame_cnt), DW'(1));
    tick();
    check("consumed_valid", DW'(data_valid), DW'(0));
    check("consumed_hold", data, {w[3], w[2], w[1], w[0]});

    // flush with word, then a lone flush
    send(w[4]); send(w[5]);
    in_flush = 1'b1;
    send(w[6]);
    in_flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", DW'(data_valid), DW'(1));
    check("flush_data", data, {IW'(0), w[6], w[5], w[4]});
    check("flush_cnt", DW'(frame_cnt), DW'(2));
    tick();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    tick();
    check("empty_flush_valid", DW'(data_valid), DW'(0));
    check("empty_flush_cnt", DW'(frame_cnt), DW'(2));

    // backpressure
    data_next = 1'b0;
    for (int i = 0; i < 8; i++) send(w[i]);
    in_valid = 1'b0;
    check("bp_in_ready", DW'(in_ready), DW'(0));
    check("bp_data1", data, {w[3], w[2], w[1], w[0]});
    check("bp_cnt1", DW'(frame_cnt), DW'(3));
    tick(); tick();
    check("bp_held_valid", DW'(data_valid), DW'(1));
    data_next = 1'b1;
    tick();
    data_next = 1'b0;
    check("bp_switch_valid", DW'(data_valid), DW'(1));
    check("bp_data2", data, {w[7], w[6], w[5], w[4]});
    check("bp_cnt2", DW'(frame_cnt), DW'(4));
    check("bp_ready_back", DW'(in_ready), DW'(1));
    data_next = 1'b1;
    tick();
    check("bp_drain", DW'(data_valid), DW'(0));

    // concurrent consume and close
    data_next = 1'b0;
    for (int i = 0; i < 7; i++) send(w[7 - i]);
    check("cc_data1", data, {w[4], w[5], w[6], w[7]});
    data_next = 1'b1;
    send(w[0]);
    in_valid = 1'b0;
    check("cc_valid", DW'(data_valid), DW'(1));
    check("cc_data2", data, {w[0], w[1], w[2], w[3]});
    check("cc_cnt", DW'(frame_cnt), DW'(6));
    check("cc_ready", DW'(in_ready), DW'(1));
    tick();

    // reset mid-operation
    data_next = 1'b0;
    for (int i = 0; i < 7; i++) send(w[i]);
    in_valid = 1'b0;
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    check("mid_rst_valid", DW'(data_valid), DW'(0));
    check("mid_rst_cnt", DW'(frame_cnt), DW'(0));
    data_next = 1'b1;
    send(w[4]); send(w[5]); send(w[6]); send(w[7]);
    in_valid = 1'b0;
    check("mid_rst_clean", data, {w[7], w[6], w[5], w[4]});
    check("mid_rst_cnt1", DW'(frame_cnt), DW'(1));
    tick();

    // idle partial frame
    send(w[2]);
    in_valid = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    for (int i = 0; i < 8; i++) tick();
    check("to_early", DW'(data_valid), DW'(0));
    tick();
`else
    stuck = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (data_valid) stuck = 1'b1;
    end
    check("no_timeout", DW'(stuck), DW'(0));
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
`endif
    check("idle_valid", DW'(data_valid), DW'(1));
    check("idle_data", data, {IW'(0), IW'(0), IW'(0), w[2]});
    check("idle_cnt", DW'(frame_cnt), DW'(2));

    // frame counter wrap
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    in_valid = 1'b1; in_flush = 1'b1; in_data = w[1];
    for (int i = 0; i < 65535; i++) tick();
    check("wrap_ffff", DW'(frame_cnt), DW'(16'hFFFF));
    tick();
    in_valid = 1'b0; in_flush = 1'b0;
    check("wrap_zero", DW'(frame_cnt), DW'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
